// File: rtl/snake_track_if.sv
// Segment stream from the snake movement stage into snake_track, plus the
// food location that must stay stable for the duration of a move.
interface snake_track_if #(
  parameter int H_LOGIC_WIDTH = 5,
  parameter int V_LOGIC_WIDTH = 5
);
  logic                     move_tick;
  logic                     seg_vld;
  logic                     seg_last;
  logic [H_LOGIC_WIDTH-1:0] seg_x;
  logic [V_LOGIC_WIDTH-1:0] seg_y;
  logic [H_LOGIC_WIDTH-1:0] food_x;
  logic [V_LOGIC_WIDTH-1:0] food_y;

  modport master (output move_tick, seg_vld, seg_last, seg_x, seg_y, food_x, food_y);
  modport slave  (input  move_tick, seg_vld, seg_last, seg_x, seg_y, food_x, food_y);
endinterface

// File: rtl/snake_track.sv
// Double-buffered 32x24 snake occupancy bitmap with self-collision, food capture and length.
// Optional macro SNAKE_TRACK_WALL_KILL_EN: a head that wraps through a wall ends the game.
module snake_track #(
  parameter int H_LOGIC_MAX     = 31,
  parameter int V_LOGIC_MAX     = 23,
  parameter int H_LOGIC_WIDTH   = 5,
  parameter int V_LOGIC_WIDTH   = 5,
  parameter int INIT_LEN        = 3,
  parameter int MAX_LEN         = 199,
  parameter int MIN_COLLIDE_LEN = 5
) (
  input  logic                     clk,
  input  logic                     DLY_RST,
  snake_track_if.slave             mv,
  input  logic [H_LOGIC_WIDTH-1:0] rd_x,
  input  logic [V_LOGIC_WIDTH-1:0] rd_y,
  output logic                     rd_occ,
  output logic                     rd_head,
  output logic [9:0]               length,
  output logic                     eat,
  output logic                     dead,
  output logic                     frame_done,
  output logic                     seq_err
);
  localparam int COLS  = H_LOGIC_MAX + 1;
  localparam int CELLS = COLS * (V_LOGIC_MAX + 1);
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = $clog2(MAX_LEN + 3);

  typedef enum logic [1:0] {IDLE, HEAD, BODY, COMMIT} state_t;
  typedef struct packed {
    logic [H_LOGIC_WIDTH-1:0] x;
    logic [V_LOGIC_WIDTH-1:0] y;
  } coord_t;

  state_t           state;
  logic [CELLS-1:0] bank [2];
  logic             bsel;          // bank being built; display is ~bsel
  logic [CW-1:0]    seg_cnt;
  coord_t           head, chead;
  logic             hit_self, hit_food;
  logic             kill;

  logic          seg_in, rd_in, seg_is_head;
  logic [AW-1:0] seg_idx, rd_idx;

  // Compare one bit wider so the in-range test stays meaningful at full-width maxima.
  assign seg_in  = ({1'b0, mv.seg_x} <= (H_LOGIC_WIDTH+1)'(H_LOGIC_MAX)) &&
                   ({1'b0, mv.seg_y} <= (V_LOGIC_WIDTH+1)'(V_LOGIC_MAX));
  assign rd_in   = ({1'b0, rd_x} <= (H_LOGIC_WIDTH+1)'(H_LOGIC_MAX)) &&
                   ({1'b0, rd_y} <= (V_LOGIC_WIDTH+1)'(V_LOGIC_MAX));
  assign seg_idx = AW'(int'(mv.seg_y) * COLS + int'(mv.seg_x));
  assign rd_idx  = AW'(int'(rd_y) * COLS + int'(rd_x));
  assign seg_is_head = (mv.seg_x == head.x) && (mv.seg_y == head.y);

`ifdef SNAKE_TRACK_WALL_KILL_EN
  logic                     have_prev;
  logic [H_LOGIC_WIDTH-1:0] dx;
  logic [V_LOGIC_WIDTH-1:0] dy;
  assign dx   = (head.x > chead.x) ? head.x - chead.x : chead.x - head.x;
  assign dy   = (head.y > chead.y) ? head.y - chead.y : chead.y - head.y;
  assign kill = hit_self || (have_prev && ((dx == H_LOGIC_WIDTH'(H_LOGIC_MAX)) ||
                                           (dy == V_LOGIC_WIDTH'(V_LOGIC_MAX))));

  // No previous head exists until the first commit after reset.
  always_ff @(posedge clk) begin
    if (DLY_RST)              have_prev <= 1'b0;
    else if (state == COMMIT) have_prev <= 1'b1;
  end
`else
  assign kill = hit_self;
`endif

  always_ff @(posedge clk) begin
    if (DLY_RST) begin
      bank[0]    <= '0;
      bank[1]    <= '0;
      bsel       <= 1'b0;
      state      <= IDLE;
      seg_cnt    <= '0;
      head       <= '0;
      chead      <= '0;
      hit_self   <= 1'b0;
      hit_food   <= 1'b0;
      length     <= 10'(INIT_LEN);
      eat        <= 1'b0;
      dead       <= 1'b0;
      frame_done <= 1'b0;
      seq_err    <= 1'b0;
      rd_occ     <= 1'b0;
      rd_head    <= 1'b0;
    end else begin
      eat        <= 1'b0;
      frame_done <= 1'b0;
      rd_occ     <= rd_in && bank[~bsel][rd_idx];
      rd_head    <= rd_in && (rd_x == chead.x) && (rd_y == chead.y);

      case (state)
        IDLE: begin
          if (mv.seg_vld) seq_err <= 1'b1;
          if (mv.move_tick) begin
            bank[bsel] <= '0;
            seg_cnt    <= '0;
            hit_self   <= 1'b0;
            hit_food   <= 1'b0;
            state      <= HEAD;
          end
        end

        HEAD, BODY: begin
          if (mv.move_tick) begin
            // Abandon the partial frame; the display bank is untouched.
            seq_err    <= 1'b1;
            bank[bsel] <= '0;
            seg_cnt    <= '0;
            hit_self   <= 1'b0;
            hit_food   <= 1'b0;
            state      <= HEAD;
          end else if (mv.seg_vld) begin
            // Off-grid coordinates are not written but still advance the sequence.
            if (seg_in) bank[bsel][seg_idx] <= 1'b1;
            else        seq_err <= 1'b1;
            if (state == HEAD) begin
              head     <= '{x: mv.seg_x, y: mv.seg_y};
              hit_food <= (mv.seg_x == mv.food_x) && (mv.seg_y == mv.food_y);
              seg_cnt  <= CW'(1);
              state    <= mv.seg_last ? COMMIT : BODY;
            end else begin
              seg_cnt <= seg_cnt + CW'(1);
              if (length >= 10'(MIN_COLLIDE_LEN) && seg_is_head) hit_self <= 1'b1;
              if (mv.seg_last) begin
                state <= COMMIT;
              end else if (seg_cnt + CW'(1) == CW'(MAX_LEN + 2)) begin
                seq_err <= 1'b1;
                state   <= COMMIT;
              end
            end
          end
        end

        COMMIT: begin
          bsel       <= ~bsel;
          frame_done <= 1'b1;
          chead      <= head;
          if (kill) begin
            dead <= 1'b1;
          end else if (hit_food && !dead) begin
            eat <= 1'b1;
            if (length < 10'(MAX_LEN)) length <= length + 10'd1;
          end
          if (mv.seg_vld) seq_err <= 1'b1;
          state <= IDLE;
          // A move starting on the commit cycle builds into the bank just released.
          if (mv.move_tick) begin
            bank[~bsel] <= '0;
            seg_cnt     <= '0;
            hit_self    <= 1'b0;
            hit_food    <= 1'b0;
            state       <= HEAD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_track.sv
// Directed bench for snake_track: bitmap build/swap, food, self-collision, protocol errors, wall wrap.
module tb_snake_track;
  logic       clk = 1'b0;
  logic       DLY_RST;
  logic [4:0] rd_x, rd_y;
  logic       rd_occ, rd_head, eat, dead, frame_done, seq_err;
  logic [9:0] length;
  int         checks = 0;
  int         errors = 0;
  int         fd_cnt;
  logic       err_at200;

`ifdef SNAKE_TRACK_WALL_KILL_EN
  localparam logic WALL_DEAD = 1'b1;
`else
  localparam logic WALL_DEAD = 1'b0;
`endif

  always #5 clk = ~clk;

  snake_track_if mv ();

  snake_track dut (
    .clk(clk), .DLY_RST(DLY_RST), .mv(mv),
    .rd_x(rd_x), .rd_y(rd_y), .rd_occ(rd_occ), .rd_head(rd_head),
    .length(length), .eat(eat), .dead(dead), .frame_done(frame_done), .seq_err(seq_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    DLY_RST = 1'b1;
    tick();
    tick();
    DLY_RST = 1'b0;
  endtask

  task automatic move;
    mv.move_tick = 1'b1;
    tick();
    mv.move_tick = 1'b0;
  endtask

  task automatic seg(input int x, input int y, input logic last);
    mv.seg_vld  = 1'b1;
    mv.seg_x    = 5'(x);
    mv.seg_y    = 5'(y);
    mv.seg_last = last;
    tick();
    mv.seg_vld  = 1'b0;
    mv.seg_last = 1'b0;
  endtask

  task automatic food(input int x, input int y);
    mv.food_x = 5'(x);
    mv.food_y = 5'(y);
  endtask

  task automatic rd(input int x, input int y);
    rd_x = 5'(x);
    rd_y = 5'(y);
    tick();
  endtask

  // Straight snake along -x from the head; the caller ticks through COMMIT.
  task automatic run_move(input int hx, input int hy, input int n);
    move();
    for (int i = 0; i < n; i++) seg(hx - i, hy, i == n - 1);
  endtask

  initial begin
    mv.move_tick = 0; mv.seg_vld = 0; mv.seg_last = 0;
    mv.seg_x = 0; mv.seg_y = 0;
    food(20, 20);
    rd_x = 0; rd_y = 0;
    do_reset();
    check("rst_length", 32'(length), 3);
    check("rst_dead", 32'(dead), 0);
    check("rst_seq_err", 32'(seq_err), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_eat", 32'(eat), 0);
    check("rst_rd_occ", 32'(rd_occ), 0);

    // Basic three-segment frame
    move();
    seg(5, 5, 0);
    seg(4, 5, 0);
    seg(3, 5, 1);
    check("fd_before_commit", 32'(frame_done), 0);
    tick();
    check("fd_commit", 32'(frame_done), 1);
    check("eat_no_food", 32'(eat), 0);
    tick();
    check("fd_pulse_end", 32'(frame_done), 0);
    rd(4, 5);
    check("occ_4_5", 32'(rd_occ), 1);
    check("head_4_5", 32'(rd_head), 0);
    rd(6, 5);
    check("occ_6_5", 32'(rd_occ), 0);
    rd(5, 5);
    check("occ_5_5", 32'(rd_occ), 1);
    check("head_5_5", 32'(rd_head), 1);
    rd(3, 24);
    check("occ_row_oob", 32'(rd_occ), 0);
    check("head_row_oob", 32'(rd_head), 0);
    check("len_frame1", 32'(length), 3);
    check("seq_err_clean", 32'(seq_err), 0);

    // Food capture and growth to 6
    food(6, 5);
    run_move(6, 5, 4);
    tick();
    check("eat_pulse", 32'(eat), 1);
    check("len_eat1", 32'(length), 4);
    tick();
    check("eat_once", 32'(eat), 0);
    food(20, 20);
    run_move(7, 5, 5);
    tick();
    check("eat_none_grow", 32'(eat), 0);
    check("len_grown_frame", 32'(length), 4);
    food(8, 5);
    run_move(8, 5, 6);
    tick();
    check("len_eat2", 32'(length), 5);
    food(9, 5);
    run_move(9, 5, 7);
    tick();
    check("len_eat3", 32'(length), 6);
    food(20, 20);

    // Display bank holds during a build that omits (4,5)
    rd_x = 4; rd_y = 5;
    tick();
    check("hold_pre", 32'(rd_occ), 1);
    move();
    seg(12, 12, 0);
    check("hold_mid", 32'(rd_occ), 1);
    seg(11, 12, 1);
    check("hold_last", 32'(rd_occ), 1);
    tick();
    check("hold_fd", 32'(frame_done), 1);
    check("hold_at_swap", 32'(rd_occ), 1);
    tick();
    check("after_swap", 32'(rd_occ), 0);
    rd(12, 12);
    check("head_12_12", 32'(rd_head), 1);

    // Self-collision beats food
    food(10, 10);
    move();
    seg(10, 10, 0);
    seg(10, 11, 0);
    seg(11, 11, 0);
    seg(11, 10, 0);
    seg(10, 10, 0);
    seg(9, 10, 1);
    tick();
    check("dead_set", 32'(dead), 1);
    check("dead_no_eat", 32'(eat), 0);
    check("dead_len", 32'(length), 6);
    food(3, 3);
    run_move(3, 3, 1);
    tick();
    check("dead_fd", 32'(frame_done), 1);
    check("dead_no_eat2", 32'(eat), 0);
    check("dead_len_frozen", 32'(length), 6);
    check("dead_sticky", 32'(dead), 1);
    rd(3, 3);
    check("dead_map_upd", 32'(rd_occ), 1);

    // move_tick mid-BODY discards the partial frame
    do_reset();
    food(20, 20);
    move();
    seg(5, 5, 0);
    seg(4, 5, 0);
    move();
    check("restart_seq_err", 32'(seq_err), 1);
    check("restart_no_fd", 32'(frame_done), 0);
    rd(5, 5);
    check("restart_no_swap", 32'(rd_occ), 0);
    check("restart_no_fd2", 32'(frame_done), 0);
    seg(2, 2, 1);
    tick();
    check("restart_fd", 32'(frame_done), 1);
    rd(2, 2);
    check("restart_occ_new", 32'(rd_occ), 1);
    rd(5, 5);
    check("restart_occ_old", 32'(rd_occ), 0);

    // Overrun: 202 segments, no seg_last
    do_reset();
    food(31, 23);
    fd_cnt = 0;
    err_at200 = 1'bx;
    move();
    for (int i = 0; i < 202; i++) begin
      seg(i % 32, i / 32, 0);
      if (frame_done) fd_cnt++;
      if (i == 199) err_at200 = seq_err;
    end
    tick();
    check("ovr_err_at200", 32'(err_at200), 0);
    check("ovr_seq_err", 32'(seq_err), 1);
    check("ovr_fd_once", 32'(fd_cnt), 1);
    check("ovr_len", 32'(length), 3);
    rd(8, 6);
    check("ovr_occ_201st", 32'(rd_occ), 1);
    rd(9, 6);
    check("ovr_occ_202nd", 32'(rd_occ), 0);

    // Wall wrap: first move exempt, then 31 -> 0
    do_reset();
    food(20, 20);
    run_move(31, 7, 1);
    tick();
    check("wall_first", 32'(dead), 0);
    run_move(0, 7, 1);
    tick();
    check("wall_wrap", 32'(dead), 32'(WALL_DEAD));
    check("wall_len", 32'(length), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
